hilo_muldiv: RTL and testbench

//  Execute-stage multiply/divide unit and owner of the HI/LO registers. It consumes the 8-bit alucontrol

---
 rtl/hilo_muldiv.sv | 236 +++++++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: execute-stage multiply/divide unit that owns the HI/LO registers.
// Sequential shift-add multiply and restoring radix-2 divide, one bit per cycle.
// Optional macro HILO_FAST_MUL_EN: MULT/MULTU become a single-cycle combinational multiply.
module hilo_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [7:0]       alucontrol_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
   localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
   localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
   localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] work_hi_q, work_hi_d;
   logic [WIDTH-1:0] work_lo_q, work_lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic             neg_q, neg_d;
   logic             sign_a_q, sign_a_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic             is_mul, is_div, is_signed, muldiv_stalls;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH-1:0] src_hi, src_lo, src_opnd;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
   logic [2*WIDTH-1:0] mul_prod, mul_res;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] div_rest;
   logic             div_ge;
   logic [WIDTH-1:0] div_hi_n, div_lo_n, div_q, div_r;
`ifdef HILO_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
`endif

   // Opcode decode and operand magnitudes for the accept cycle
   always_comb begin
      is_mul    = (alucontrol_i == EXE_MULT_OP) || (alucontrol_i == EXE_MULTU_OP);
      is_div    = (alucontrol_i == EXE_DIV_OP)  || (alucontrol_i == EXE_DIVU_OP);
      is_signed = (alucontrol_i == EXE_MULT_OP) || (alucontrol_i == EXE_DIV_OP);
      mag_a     = (is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
      mag_b     = (is_signed && b_i[WIDTH-1]) ? -b_i : b_i;
`ifdef HILO_FAST_MUL_EN
      muldiv_stalls = is_div;
`else
      muldiv_stalls = is_mul || is_div;
`endif
   end

   // One iteration of multiply and divide; accept cycle runs the first iteration on fresh operands
   always_comb begin
      if (state_q == S_IDLE) begin
         src_hi   = '0;
         src_lo   = is_mul ? mag_b : mag_a;
         src_opnd = is_mul ? mag_a : mag_b;
      end else begin
         src_hi   = work_hi_q;
         src_lo   = work_lo_q;
         src_opnd = opnd_q;
      end
      mul_sum  = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_opnd} : (WIDTH+1)'(0));
      mul_hi_n = mul_sum[WIDTH:1];
      mul_lo_n = {mul_sum[0], src_lo[WIDTH-1:1]};
      mul_prod = {mul_hi_n, mul_lo_n};
      mul_res  = neg_q ? -mul_prod : mul_prod;

      div_diff = {src_hi, src_lo[WIDTH-1]} - {1'b0, src_opnd};
      div_rest = {src_hi[WIDTH-2:0], src_lo[WIDTH-1]};
      div_ge   = ~div_diff[WIDTH];
      div_hi_n = div_ge ? div_diff[WIDTH-1:0] : div_rest;
      div_lo_n = {src_lo[WIDTH-2:0], div_ge};
      div_q    = neg_q ? -div_lo_n : div_lo_n;
      div_r    = sign_a_q ? -div_hi_n : div_hi_n;
   end

`ifdef HILO_FAST_MUL_EN
   // Single-cycle full-width product
   always_comb begin
      fast_a    = is_signed ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
      fast_b    = is_signed ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
      fast_prod = fast_a * fast_b;
   end
`endif

   // Next-state, datapath and HI/LO update
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_hi_d = work_hi_q;
      work_lo_d = work_lo_q;
      opnd_d    = opnd_q;
      dvd_d     = dvd_q;
      neg_d     = neg_q;
      sign_a_d  = sign_a_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start_i && !flush_i) begin
               if (is_mul) begin
`ifdef HILO_FAST_MUL_EN
                  hi_d   = fast_prod[2*WIDTH-1:WIDTH];
                  lo_d   = fast_prod[WIDTH-1:0];
                  done_d = 1'b1;
`else
                  state_d   = S_MUL;
                  cnt_d     = CNT_W'(1);
                  work_hi_d = mul_hi_n;
                  work_lo_d = mul_lo_n;
                  opnd_d    = src_opnd;
                  neg_d     = is_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                  sign_a_d  = is_signed && a_i[WIDTH-1];
`endif
               end else if (is_div) begin
                  state_d   = S_DIV;
                  cnt_d     = CNT_W'(1);
                  work_hi_d = div_hi_n;
                  work_lo_d = div_lo_n;
                  opnd_d    = src_opnd;
                  dvd_d     = a_i;
                  dbz_d     = (b_i == '0);
                  neg_d     = is_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                  sign_a_d  = is_signed && a_i[WIDTH-1];
               end else if (alucontrol_i == EXE_MTHI_OP) begin
                  hi_d = a_i;
               end else if (alucontrol_i == EXE_MTLO_OP) begin
                  lo_d = a_i;
               end
            end
         end
         S_MUL: begin
            if (flush_i) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               work_hi_d = mul_hi_n;
               work_lo_d = mul_lo_n;
               cnt_d     = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  hi_d    = mul_res[2*WIDTH-1:WIDTH];
                  lo_d    = mul_res[WIDTH-1:0];
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         S_DIV: begin
            if (flush_i) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               work_hi_d = div_hi_n;
               work_lo_d = div_lo_n;
               cnt_d     = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  hi_d    = dbz_q ? dvd_q : div_r;
                  lo_d    = dbz_q ? {WIDTH{1'b1}} : div_q;
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         work_hi_q <= '0;
         work_lo_q <= '0;
         opnd_q    <= '0;
         dvd_q     <= '0;
         neg_q     <= 1'b0;
         sign_a_q  <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_hi_q <= work_hi_d;
         work_lo_q <= work_lo_d;
         opnd_q    <= opnd_d;
         dvd_q     <= dvd_d;
         neg_q     <= neg_d;
         sign_a_q  <= sign_a_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   // Pipeline hold: accept cycle of a multi-cycle op plus every iteration cycle
   assign stall_o = !rst && (((state_q == S_IDLE) && start_i && muldiv_stalls && !flush_i) ||
                             (state_q == S_MUL) || (state_q == S_DIV));
   assign done_o  = done_q;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv (default 32-bit build).
module tb_hilo_muldiv;

   localparam logic [7:0] MTHI  = 8'b0001_0001;
   localparam logic [7:0] MTLO  = 8'b0001_0011;
   localparam logic [7:0] MULT  = 8'b0001_1000;
   localparam logic [7:0] MULTU = 8'b0001_1001;
   localparam logic [7:0] DIV   = 8'b0001_1010;
   localparam logic [7:0] DIVU  = 8'b0001_1011;
`ifdef HILO_FAST_MUL_EN
   localparam int MUL_STALLS = 0;
`else
   localparam int MUL_STALLS = 32;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [7:0]  alucontrol_i;
   logic [31:0] a_i, b_i;
   logic        flush_i;
   logic        stall_o, done_o;
   logic [31:0] hi_o, lo_o;

   int errors = 0;
   int checks = 0;
   int st, dn;

   hilo_muldiv #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .alucontrol_i(alucontrol_i),
      .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .stall_o(stall_o),
      .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Issue one op like the pipeline would: held in E while stalled, gone once stall drops
   task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output int dones);
      logic s;
      start_i = 1'b1; alucontrol_i = op; a_i = a; b_i = b;
      stalls = 0; dones = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         s = stall_o;
         if (s) stalls++;
         if (done_o) dones++;
         @(posedge clk); #1;
         if (!s) start_i = 1'b0;
         if (dones != 0) break;
      end
      start_i = 1'b0;
      @(negedge clk);
      if (done_o) dones++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start_i = 1'b0; alucontrol_i = '0; a_i = '0; b_i = '0; flush_i = 1'b0;
      #12;
      check("rst_stall", 64'(stall_o), 64'd0);
      check("rst_done",  64'(done_o),  64'd0);
      check("rst_hi",    64'(hi_o),    64'd0);
      check("rst_lo",    64'(lo_o),    64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // MTHI then MTLO: single cycle, never stalls
      start_i = 1'b1; alucontrol_i = MTHI; a_i = 32'h1234_5678;
      @(negedge clk);
      check("mthi_stall", 64'(stall_o), 64'd0);
      @(posedge clk); #1;
      alucontrol_i = MTLO; a_i = 32'h9ABC_DEF0;
      @(negedge clk);
      check("mthi_hi",    64'(hi_o),    64'h1234_5678);
      check("mtlo_stall", 64'(stall_o), 64'd0);
      check("mthi_done",  64'(done_o),  64'd0);
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      check("mtlo_lo",   64'(lo_o),   64'h9ABC_DEF0);
      check("mtlo_done", 64'(done_o), 64'd0);

      // Unrelated opcode is ignored
      @(posedge clk); #1;
      start_i = 1'b1; alucontrol_i = 8'h20; a_i = 32'hFFFF_FFFF; b_i = 32'h1;
      @(negedge clk);
      check("other_stall", 64'(stall_o), 64'd0);
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      check("other_hilo", {32'(hi_o), 32'(lo_o)}, {32'h1234_5678, 32'h9ABC_DEF0});
      check("other_done", 64'(done_o), 64'd0);

      // Multiplies
      @(posedge clk); #1;
      run_op(MULT, 32'hFFFF_FFFE, 32'd3, st, dn);
      check("mult_hilo",   {32'(hi_o), 32'(lo_o)}, 64'hFFFF_FFFF_FFFF_FFFA);
      check("mult_stall",  64'(st), 64'(MUL_STALLS));
      check("mult_done",   64'(dn), 64'd1);
      @(posedge clk); #1;
      run_op(MULTU, 32'hFFFF_FFFE, 32'd3, st, dn);
      check("multu_hilo",  {32'(hi_o), 32'(lo_o)}, 64'h0000_0002_FFFF_FFFA);
      check("multu_stall", 64'(st), 64'(MUL_STALLS));
      check("multu_done",  64'(dn), 64'd1);

      // Divides
      @(posedge clk); #1;
      run_op(DIV, 32'hFFFF_FFF9, 32'd2, st, dn);
      check("div_hilo",   {32'(hi_o), 32'(lo_o)}, 64'hFFFF_FFFF_FFFF_FFFD);
      check("div_stall",  64'(st), 64'd32);
      check("div_done",   64'(dn), 64'd1);
      @(posedge clk); #1;
      run_op(DIVU, 32'd7, 32'd2, st, dn);
      check("divu_hilo",  {32'(hi_o), 32'(lo_o)}, 64'h0000_0001_0000_0003);
      check("divu_stall", 64'(st), 64'd32);
      @(posedge clk); #1;
      run_op(DIVU, 32'd5, 32'd0, st, dn);
      check("divu0_hilo",  {32'(hi_o), 32'(lo_o)}, 64'h0000_0005_FFFF_FFFF);
      check("divu0_stall", 64'(st), 64'd32);
      check("divu0_done",  64'(dn), 64'd1);
      @(posedge clk); #1;
      run_op(DIV, 32'hFFFF_FFF0, 32'd0, st, dn);
      check("div0_hilo",   {32'(hi_o), 32'(lo_o)}, 64'hFFFF_FFF0_FFFF_FFFF);
      @(posedge clk); #1;
      run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, dn);
      check("divovf_hilo", {32'(hi_o), 32'(lo_o)}, 64'h0000_0000_8000_0000);

      // Flush mid-divide: nothing committed, then a fresh DIVU runs normally
      @(posedge clk); #1;
      start_i = 1'b1; alucontrol_i = DIV; a_i = 32'd100; b_i = 32'd7;
      dn = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done_o) dn++;
         @(posedge clk); #1;
      end
      flush_i = 1'b1;
      @(negedge clk);
      check("flush_stall_in", 64'(stall_o), 64'd1);
      if (done_o) dn++;
      @(posedge clk); #1;
      flush_i = 1'b0; start_i = 1'b0;
      @(negedge clk);
      if (done_o) dn++;
      check("flush_stall_out", 64'(stall_o), 64'd0);
      check("flush_done",      64'(dn), 64'd0);
      check("flush_hilo",      {32'(hi_o), 32'(lo_o)}, 64'h0000_0000_8000_0000);
      @(posedge clk); #1;
      run_op(DIVU, 32'd9, 32'd4, st, dn);
      check("postflush_hilo",  {32'(hi_o), 32'(lo_o)}, 64'h0000_0001_0000_0002);
      check("postflush_stall", 64'(st), 64'd32);
      check("postflush_done",  64'(dn), 64'd1);

      // Asynchronous reset in the middle of a divide
      @(posedge clk); #1;
      start_i = 1'b1; alucontrol_i = DIV; a_i = 32'd100; b_i = 32'd7;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_stall", 64'(stall_o), 64'd0);
      check("arst_hilo",  {32'(hi_o), 32'(lo_o)}, 64'd0);
      check("arst_done",  64'(done_o), 64'd0);
      start_i = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("arst_idle_stall", 64'(stall_o), 64'd0);
      check("arst_idle_done",  64'(done_o), 64'd0);
      @(posedge clk); #1;
      run_op(MULTU, 32'd7, 32'd6, st, dn);
      check("arst_mul_hilo", {32'(hi_o), 32'(lo_o)}, 64'd42);
      check("arst_mul_done", 64'(dn), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
